ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Decoupled instruction-fetch stage for the bexkat1 pipeline with a small prefetch queue. Issues sequential 32-bit word reads on the instruction bus, buffers returned words, and assembles one- or two-word instructions into the 64-bit `ir` consumed by decode. Sits between the instruction port of `ram2` and `idecode`. Redirects on `pc_set` from the memory stage.

## Interface
- `DEPTH`, 4 — queue depth in 32-bit words; power of two, minimum 2.
- `RESET_PC`, 32'h0 — first fetch address after reset.

- `clk_i`  in  1  — clock.
- `rst_i`  in  1  — asynchronous, active-low reset.
- `stall_i`  in  1  — hold `ir`/`pc`; no instruction consumed.
- `pc_set`  in  1  — redirect request.
- `pc_in`  in  32  — redirect target, word aligned.
- `ir`  out  64  — instruction: [63:32] first word, [31:0] immediate word or 0; 64'h0 is a bubble.
- `pc`  out  32  — address of the first word of `ir`.
- `bus_adr`  out  32  — fetch address.
- `bus_cyc`  out  1  — bus cycle/strobe.
- `bus_ack`  in  1  — data valid on `bus_in`.
- `bus_in`  in  32  — read data.

## Operation
- Instruction length: first-word bit 0 = 1 means two words; otherwise one word.
- Fetch side: one outstanding request maximum. Issue when `count + outstanding < DEPTH` and no flush is pending. Hold `bus_adr`/`bus_cyc` stable until `bus_ack`. On ack, push `bus_in` and increment the fetch address by 4; wraps at 2^32.
- Queue holds words and the address of each queue head word.
- Issue side (`stall_i`=0):
  - Head is one-word and `count`>=1: pop 1; `ir` = {w0, 32'h0}.
  - Head is two-word and `count`>=2: pop 2; `ir` = {w0, w1}.
  - Otherwise: `ir` = 0 and `pc` unchanged.
- `stall_i`=1: `ir`/`pc` hold; fetch continues until the queue is full.
- A push and a pop in the same cycle are both honoured. `count` stays in 0..DEPTH.
- `pc_set`:
  - Same cycle: flush the queue, force `ir` to 0 on the next edge, and load the fetch address with `pc_in`.
  - An outstanding request has `bus_cyc` dropped on the next edge. Any `bus_ack` in the `pc_set` cycle is discarded.
  - Fetch restarts at `pc_in` one cycle later.
  - `pc_set` overrides `stall_i`.
- States: IDLE (no request), REQ (`bus_cyc`=1, waiting ack), FLUSH (one cycle, `bus_cyc`=0).
  - IDLE→REQ when room is available.
  - REQ→REQ on ack when room remains; REQ→IDLE on ack when full.
  - Any state→FLUSH on `pc_set`.
  - FLUSH→REQ.

## Timing
- Reset values: `ir`=0, `pc`=`RESET_PC`, `bus_cyc`=0, `bus_adr`=`RESET_PC`, `count`=0, state IDLE.
- First `bus_cyc` is asserted on the first edge after reset release.
- Latency: a word acked at edge N can appear in `ir` at edge N+1; a two-word instruction needs its second word's ack.
- Back-to-back: with a one-cycle-ack memory, sustained throughput is one word per cycle. `bus_cyc` stays high across consecutive acks while the queue has room.
- Reset mid-transaction: `bus_cyc` drops immediately (asynchronous) and all state clears.

## Configuration
- `BEXKAT_FETCH_ERR_EN` defined: adds input `bus_err` (1) and output `exc_o` (1, reset 0).
  - `bus_err` in REQ terminates the request without a push.
  - The fetch side then halts until `pc_set`.
  - Once the queue drains to that point, `ir`=0 and `exc_o`=1 for one cycle, with `pc` = the faulting address.
- Not defined: no `bus_err` port, no `exc_o` port; bus errors are not detectable.

## Structure
- Shared package `bexkat1_pkg`:
  - `IR_NOP` (64'h0);
  - word/instruction width constants;
  - the fetch-state enum.
- One sub-module, `fetch_fifo`: DEPTH×(32+32) storage with push/pop1/pop2/flush and `count`.

## Test plan
- Reset, then a memory with 1-cycle ack holding 0x10000000, 0x20000000 at addresses 0, 4 → `ir`=0x10000000_00000000 with `pc`=0, then 0x20000000_00000000 with `pc`=4 on the next cycle.
- Two-word instruction 0x30000001 with immediate 0xDEADBEEF at 8 → a single `ir`=0x30000001_DEADBEEF with `pc`=8; no bubble once both words are queued.
- `stall_i` held 10 cycles → `ir`/`pc` hold, exactly DEPTH words are fetched, then `bus_cyc`=0; on release, instructions continue in order.
- `pc_set`=1, `pc_in`=0x100 coinciding with a `bus_ack` → the acked word is dropped, `ir`=0 next cycle, and the next `bus_adr`=0x100.
- Fetch address 0xFFFFFFFC → the following fetch goes to 0x00000000.
- With `BEXKAT_FETCH_ERR_EN`: `bus_err` on the fetch at 0x40 → `exc_o` pulses with `pc`=0x40; there is no further `bus_cyc` until `pc_set`.

Source files
------------

// File: rtl/bexkat1_pkg.sv
// Shared bexkat1 constants and types: instruction/word widths, the bubble
// encoding and the fetch-state enum.
package bexkat1_pkg;
  localparam int WORD_W = 32;
  localparam int IR_W   = 64;
  localparam logic [IR_W-1:0] IR_NOP = 64'h0;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_REQ   = 2'd1,
    F_FLUSH = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch word queue: DEPTH entries of {word, word address}. It can pop one
// or two words per cycle and has a single-cycle flush.
module fetch_fifo
  import bexkat1_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WORD_W-1:0]         push_word,
  input  logic [WORD_W-1:0]         push_adr,
  input  logic                      pop1,
  input  logic                      pop2,
  output logic [WORD_W-1:0]         head_word,
  output logic [WORD_W-1:0]         next_word,
  output logic [WORD_W-1:0]         head_adr,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] words [DEPTH];
  logic [WORD_W-1:0] adrs  [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr, rd_nxt;
  logic [AW:0]       npop;

  assign rd_nxt    = rd_ptr + AW'(1);
  assign head_word = words[rd_ptr];
  assign next_word = words[rd_nxt];
  assign head_adr  = adrs[rd_ptr];
  assign npop      = pop2 ? (AW+1)'(2) : (pop1 ? (AW+1)'(1) : (AW+1)'(0));

  always_ff @(posedge clk) begin
    if (push) begin
      words[wr_ptr] <= push_word;
      adrs[wr_ptr]  <= push_adr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + npop[AW-1:0];
      count  <= count + (AW+1)'(push) - npop;
    end
  end
endmodule

// File: rtl/ifetch_queue.sv
// bexkat1 decoupled instruction fetch with prefetch queue. The optional
// BEXKAT_FETCH_ERR_EN build adds bus_err / exc_o fault reporting.
module ifetch_queue
  import bexkat1_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              pc_set,
  input  logic [WORD_W-1:0] pc_in,
  output logic [IR_W-1:0]   ir,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] bus_adr,
  output logic              bus_cyc,
  input  logic              bus_ack,
  input  logic [WORD_W-1:0] bus_in
`ifdef BEXKAT_FETCH_ERR_EN
  ,
  input  logic              bus_err,
  output logic              exc_o
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  logic [CW-1:0]     count;
  logic [CW:0]       level;
  logic [WORD_W-1:0] w0, w1, a0, err_adr;
  logic              push, pop1, pop2, room, err_hit, halted, exc_fire;

  assign push = (state == F_REQ) && bus_ack && !pc_set && !err_hit;
  assign pop1 = !pc_set && !stall_i && (count >= CW'(1)) && !w0[0];
  assign pop2 = !pc_set && !stall_i && (count >= CW'(2)) &&  w0[0];
  // Occupancy after this edge decides whether another request may be issued.
  assign level = {1'b0, count} + (CW+1)'(push)
               - (pop2 ? (CW+1)'(2) : (pop1 ? (CW+1)'(1) : (CW+1)'(0)));
  assign room  = level < (CW+1)'(DEPTH);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .flush     (pc_set),
    .push      (push),
    .push_word (bus_in),
    .push_adr  (bus_adr),
    .pop1      (pop1),
    .pop2      (pop2),
    .head_word (w0),
    .next_word (w1),
    .head_adr  (a0),
    .count     (count)
  );

`ifdef BEXKAT_FETCH_ERR_EN
  logic exc_pend;

  assign err_hit  = (state == F_REQ) && bus_err && !pc_set;
  // Fault is reported only once nothing older can issue.
  assign exc_fire = exc_pend && !pc_set && !stall_i && !pop1 && !pop2;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      halted   <= 1'b0;
      exc_pend <= 1'b0;
      err_adr  <= '0;
      exc_o    <= 1'b0;
    end else begin
      exc_o <= exc_fire;
      if (pc_set) begin
        halted   <= 1'b0;
        exc_pend <= 1'b0;
      end else if (err_hit) begin
        halted   <= 1'b1;
        exc_pend <= 1'b1;
        err_adr  <= bus_adr;
      end else if (exc_fire) begin
        exc_pend <= 1'b0;
      end
    end
  end
`else
  assign err_hit  = 1'b0;
  assign halted   = 1'b0;
  assign exc_fire = 1'b0;
  assign err_adr  = RESET_PC;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= F_IDLE;
      bus_cyc <= 1'b0;
      bus_adr <= RESET_PC;
    end else if (pc_set) begin
      state   <= F_FLUSH;
      bus_cyc <= 1'b0;
      bus_adr <= pc_in;
    end else begin
      case (state)
        F_IDLE: if (room && !halted) begin
          state   <= F_REQ;
          bus_cyc <= 1'b1;
        end
        F_REQ: if (err_hit) begin
          state   <= F_IDLE;
          bus_cyc <= 1'b0;
        end else if (bus_ack) begin
          bus_adr <= bus_adr + 32'd4;
          if (!room) begin
            state   <= F_IDLE;
            bus_cyc <= 1'b0;
          end
        end
        F_FLUSH: begin
          state   <= F_REQ;
          bus_cyc <= 1'b1;
        end
        default: begin
          state   <= F_IDLE;
          bus_cyc <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ir <= IR_NOP;
      pc <= RESET_PC;
    end else if (pc_set) begin
      ir <= IR_NOP;
    end else if (!stall_i) begin
      if (pop1) begin
        ir <= {w0, 32'h0};
        pc <= a0;
      end else if (pop2) begin
        ir <= {w0, w1};
        pc <= a0;
      end else if (exc_fire) begin
        ir <= IR_NOP;
        pc <= err_adr;
      end else begin
        ir <= IR_NOP;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: zero-wait memory model, hand-computed
// ir/pc/bus expectations for sequential, two-word, stall, redirect and wrap.
module tb_ifetch_queue;
  logic        clk = 1'b0;
  logic        rst_i, stall_i, pc_set;
  logic [31:0] pc_in, pc, bus_adr, bus_in;
  logic [63:0] ir;
  logic        bus_cyc, bus_ack, bus_err_w;
  logic        err_on;
  logic [31:0] err_at;
`ifdef BEXKAT_FETCH_ERR_EN
  logic        exc_o;
`endif

  logic [31:0] mem [0:127];
  int total = 0;
  int bad   = 0;
  int acks  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'hFFFF_FFFC) return 32'hA000_0000;
    if (a < 32'h200) return mem[a[8:2]];
    return 32'h0;
  endfunction

  assign bus_err_w = err_on && bus_cyc && (bus_adr == err_at);
  assign bus_ack   = bus_cyc && !bus_err_w;
  assign bus_in    = mem_rd(bus_adr);

  always @(posedge clk) if (bus_cyc && bus_ack) acks++;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .stall_i (stall_i),
    .pc_set  (pc_set),
    .pc_in   (pc_in),
    .ir      (ir),
    .pc      (pc),
    .bus_adr (bus_adr),
    .bus_cyc (bus_cyc),
    .bus_ack (bus_ack),
    .bus_in  (bus_in)
`ifdef BEXKAT_FETCH_ERR_EN
    ,
    .bus_err (bus_err_w),
    .exc_o   (exc_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] hold_ir;
  logic [31:0] hold_pc;
  int          acks0;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h7000_0000 | (32'(i) << 8);
    mem[0] = 32'h1000_0000;
    mem[1] = 32'h2000_0000;
    mem[2] = 32'h3000_0001;
    mem[3] = 32'hDEAD_BEEF;
    mem[4] = 32'h4000_0000;
    mem[5] = 32'h5000_0000;
    err_on = 1'b0; err_at = 32'h0;
    rst_i = 1'b0; stall_i = 1'b0; pc_set = 1'b0; pc_in = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir", ir, 64'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_cyc", bus_cyc, 1'b0);
    chk("rst_adr", bus_adr, 32'h0);
    rst_i = 1'b1;

    tick; // E1: first request goes out
    chk("first_cyc", bus_cyc, 1'b1);
    chk("first_adr", bus_adr, 32'h0);
    tick; // E2: word 0 pushed, not yet issued
    chk("e2_ir", ir, 64'h0);
    tick;
    chk("w0_ir", ir, 64'h1000_0000_0000_0000);
    chk("w0_pc", pc, 32'h0);
    tick;
    chk("w1_ir", ir, 64'h2000_0000_0000_0000);
    chk("w1_pc", pc, 32'h4);
    tick; // two-word head, immediate still in flight
    chk("half_ir", ir, 64'h0);
    tick;
    chk("dw_ir", ir, 64'h3000_0001_DEAD_BEEF);
    chk("dw_pc", pc, 32'h8);
    tick;
    chk("w4_ir", ir, 64'h4000_0000_0000_0000);
    chk("w4_pc", pc, 32'h10);

    // Stall: one word (0x14) already queued, so three more fill DEPTH=4.
    stall_i = 1'b1;
    hold_ir = ir; hold_pc = pc; acks0 = acks;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("stall_ir", ir, hold_ir);
      chk("stall_pc", pc, hold_pc);
    end
    chk("stall_acks", 64'(acks - acks0), 64'd3);
    chk("stall_cyc", bus_cyc, 1'b0);
    chk("stall_adr", bus_adr, 32'h24);
    stall_i = 1'b0;
    tick;
    chk("rel_ir0", ir, 64'h5000_0000_0000_0000);
    chk("rel_pc0", pc, 32'h14);
    tick;
    chk("rel_ir1", ir, 64'h7000_0600_0000_0000);
    chk("rel_pc1", pc, 32'h18);

    // Redirect while the word at 0x28 is being acked.
    pc_set = 1'b1; pc_in = 32'h100;
    chk("set_ack", bus_ack, 1'b1);
    tick;
    pc_set = 1'b0;
    chk("set_ir", ir, 64'h0);
    chk("set_cyc", bus_cyc, 1'b0);
    chk("set_adr", bus_adr, 32'h100);
    tick;
    chk("restart_cyc", bus_cyc, 1'b1);
    chk("restart_adr", bus_adr, 32'h100);
    tick;
    chk("flushed_ir", ir, 64'h0);
    tick;
    chk("tgt_ir", ir, 64'h7000_4000_0000_0000);
    chk("tgt_pc", pc, 32'h100);

    // Address wrap at 2^32.
    pc_set = 1'b1; pc_in = 32'hFFFF_FFFC;
    tick;
    pc_set = 1'b0;
    chk("wrap_set", bus_adr, 32'hFFFF_FFFC);
    tick;
    tick;
    chk("wrap_adr", bus_adr, 32'h0);
    tick;
    chk("wrap_ir", ir, 64'hA000_0000_0000_0000);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    tick;
    chk("wrap_ir2", ir, 64'h1000_0000_0000_0000);
    chk("wrap_pc2", pc, 32'h0);

`ifdef BEXKAT_FETCH_ERR_EN
    begin
      bit seen;
      seen = 1'b0;
      err_on = 1'b1; err_at = 32'h40;
      pc_set = 1'b1; pc_in = 32'h40;
      tick;
      pc_set = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
        tick;
        if (exc_o) seen = 1'b1;
      end
      chk("exc_seen", seen, 1'b1);
      chk("exc_pc", pc, 32'h40);
      chk("exc_ir", ir, 64'h0);
      tick;
      chk("exc_pulse", exc_o, 1'b0);
      for (int i = 0; i < 5; i++) begin
        tick;
        chk("halt_cyc", bus_cyc, 1'b0);
      end
      err_on = 1'b0;
      pc_set = 1'b1; pc_in = 32'h0;
      tick;
      pc_set = 1'b0;
      tick;
      chk("recover_cyc", bus_cyc, 1'b1);
    end
`endif

    // Asynchronous reset while a request is open.
    tick;
    chk("pre_rst_cyc", bus_cyc, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_cyc", bus_cyc, 1'b0);
    chk("arst_adr", bus_adr, 32'h0);
    chk("arst_ir", ir, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
